// File: rtl/fifo_rd_streamer_16_if.sv
// Read-side FIFO handshake plus the re-timed valid/ready output stream of fifo_rd_streamer_16.
// The master modport is the streamer's view; slave is the FIFO/consumer view.
interface fifo_rd_streamer_16_if #(
    parameter int DATA_WIDTH = 64
) ();
    logic                  fifo_read_req;
    logic                  fifo_read_ready;
    logic [DATA_WIDTH-1:0] fifo_read_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (
        output fifo_read_req,
        input  fifo_read_ready,
        input  fifo_read_data,
        output m_valid,
        input  m_ready,
        output m_data,
        output m_last
    );

    modport slave (
        input  fifo_read_req,
        output fifo_read_ready,
        output fifo_read_data,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_last
    );
endinterface

// File: rtl/fifo_rd_streamer_16.sv
// Command-driven FIFO read master: pops num_words words, hides the one-cycle FIFO read
// latency behind a 2-entry register buffer and streams them out with last/done marking.
module fifo_rd_streamer_16 #(
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] num_words,
    output logic                 busy,
    output logic                 done,
    fifo_rd_streamer_16_if.master bus
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            r_state;
    logic [LEN_WIDTH-1:0]  r_reqLeft;
    logic [LEN_WIDTH-1:0]  r_outLeft;
    logic                  r_done;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_buf [2];
    logic                  r_head;
    logic [1:0]            r_occ;

    logic                  w_valid;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_issue;
    logic                  w_lastHs;
    logic                  w_tail;
    logic [2:0]            w_used;
    logic [2:0]            w_limit;

    assign w_valid = (r_occ != 2'd0);
    assign w_pop   = w_valid && bus.m_ready;
    assign w_push  = r_inflight;

    // A pop may issue only if buffer plus in-flight word still leave a slot, counting the
    // slot freed by this cycle's output handshake; written as a compare to avoid underflow.
    assign w_used  = {1'b0, r_occ} + {2'b0, r_inflight};
    assign w_limit = 3'd2 + {2'b0, w_pop};
    assign w_issue = (r_state == ST_RUN) && bus.fifo_read_ready
                     && (r_reqLeft != '0) && (w_used < w_limit);

    assign w_lastHs = (r_state == ST_RUN) && w_pop && (r_outLeft == LEN_WIDTH'(1));
    assign w_tail   = r_head ^ r_occ[0];

    assign bus.fifo_read_req = w_issue;
    assign bus.m_valid       = w_valid;
    assign bus.m_data        = r_buf[r_head];
    assign bus.m_last        = w_valid && (r_outLeft == LEN_WIDTH'(1));
    assign busy              = (r_state == ST_RUN);
    assign done              = r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_reqLeft <= '0;
            r_outLeft <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (num_words != '0) begin
                            r_reqLeft <= num_words;
                            r_outLeft <= num_words;
                            r_state   <= ST_RUN;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_issue) begin
                        r_reqLeft <= r_reqLeft - LEN_WIDTH'(1);
                    end
                    if (w_pop && (r_outLeft != '0)) begin
                        r_outLeft <= r_outLeft - LEN_WIDTH'(1);
                    end
                    if (w_lastHs) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Returned FIFO data lands in the tail slot; at full occupancy a write is only possible
    // alongside a pop, and then the tail slot is the one the head is just vacating.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight <= 1'b0;
            r_head     <= 1'b0;
            r_occ      <= 2'd0;
            r_buf[0]   <= '0;
            r_buf[1]   <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_push) begin
                r_buf[w_tail] <= bus.fifo_read_data;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end
endmodule

// File: tb/tb_fifo_rd_streamer_16.sv
// Bench for fifo_rd_streamer_16: a queue-based upstream FIFO and scoreboard judge a table of
// directed transfers, a mid-transfer reset sequence and randomized transfers.
module tb_fifo_rd_streamer_16;
    localparam int DW = 64;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [LW-1:0] num_words;
    logic          busy;
    logic          done;

    fifo_rd_streamer_16_if #(.DATA_WIDTH(DW)) bus ();

    fifo_rd_streamer_16 #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_words (num_words),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int numWords;
        int readyMode;
        int preload;
        int trickle;
        int pushGap;
        int restartAt;
        int expDone;
    } vec_t;

    int nChecks = 0;
    int nFails  = 0;

    logic [DW-1:0] fifoQ[$];
    logic [DW-1:0] refQ[$];
    logic [DW-1:0] nextWord;
    logic [DW-1:0] prevData;
    bit            randData;
    bit            busyExp;
    bit            doneExp;
    bit            prevStall;
    bit            prevLast;
    int            popsTotal;
    int            hsTotal;
    int            popsInCase;
    int            hsInXfer;
    int            xferLen;
    int            cycleNo;
    int            doneCycle;
    int            readyMode;
    int            pushLeft;
    int            pushGap;
    int            restartAt;

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cycleNo);
        end
    endtask

    task automatic pushWord();
        logic [DW-1:0] w;
        if (randData) begin
            w = {$urandom, $urandom};
        end else begin
            w = nextWord;
            nextWord = nextWord + 64'd1;
        end
        fifoQ.push_back(w);
        refQ.push_back(w);
    endtask

    // Drives the inputs for the cycle numbered cycleNo, just after the preceding edge.
    task automatic applyStimulus();
        case (readyMode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = ((cycleNo % 4) == 0) || ((cycleNo % 4) == 3);
            default: bus.m_ready = 1'($urandom_range(0, 1));
        endcase
        if (pushLeft > 0) begin
            if ((pushGap > 0 && (cycleNo % pushGap) == 0) || (pushGap < 0 && $urandom_range(0, 1) == 1)) begin
                pushWord();
                pushLeft--;
            end
        end
        if (restartAt == cycleNo) begin
            start     = 1'b1;
            num_words = LW'(5);
        end
        bus.fifo_read_ready = (fifoQ.size() != 0);
    endtask

    task automatic stepCycle();
        bit hs;
        bit pop;
        bit lastHs;
        bit accStart;
        bit zeroStart;
        @(negedge clk);
        checkOutput("busy", 64'(busy), 64'(busyExp));
        checkOutput("done", 64'(done), 64'(doneExp));
        checkOutput("occupancy_bound", 64'((popsTotal - hsTotal) <= 2), 64'(1));
        checkOutput("last_without_valid", 64'(bus.m_last && !bus.m_valid), 64'(0));
        if (bus.fifo_read_req) begin
            checkOutput("req_without_ready", 64'(bus.fifo_read_ready), 64'(1));
        end
        if (prevStall) begin
            checkOutput("stall_valid", 64'(bus.m_valid), 64'(1));
            checkOutput("stall_data", bus.m_data, prevData);
            checkOutput("stall_last", 64'(bus.m_last), 64'(prevLast));
        end
        hs  = bus.m_valid && bus.m_ready;
        pop = bus.fifo_read_req && bus.fifo_read_ready;
        if (hs) begin
            hsInXfer++;
            hsTotal++;
            if (refQ.size() == 0) begin
                checkOutput("data_unexpected", bus.m_data, 64'hDEAD_0000_DEAD_0000 ^ bus.m_data ^ 64'd1);
            end else begin
                checkOutput("data", bus.m_data, refQ.pop_front());
            end
            checkOutput("last", 64'(bus.m_last), 64'(hsInXfer == xferLen));
        end
        if (done && doneCycle < 0) begin
            doneCycle = cycleNo;
        end
        if (pop) begin
            popsTotal++;
            popsInCase++;
        end
        prevStall = bus.m_valid && !bus.m_ready;
        prevData  = bus.m_data;
        prevLast  = bus.m_last;
        lastHs    = hs && busyExp && (hsInXfer == xferLen);
        accStart  = start && !busyExp && (num_words != '0);
        zeroStart = start && !busyExp && (num_words == '0);
        doneExp   = lastHs || zeroStart;
        busyExp   = busyExp ? !lastHs : accStart;
        if (accStart) begin
            xferLen  = int'(num_words);
            hsInXfer = 0;
        end
        @(posedge clk);
        #1;
        if (pop && fifoQ.size() != 0) begin
            bus.fifo_read_data = fifoQ.pop_front();
        end
        start = 1'b0;
        cycleNo++;
        applyStimulus();
    endtask

    task automatic runCase(input vec_t v);
        doneCycle  = -1;
        popsInCase = 0;
        hsInXfer   = 0;
        cycleNo    = 0;
        readyMode  = v.readyMode;
        pushLeft   = v.trickle;
        pushGap    = v.pushGap;
        restartAt  = v.restartAt;
        repeat (v.preload) pushWord();
        start     = 1'b1;
        num_words = LW'(v.numWords);
        applyStimulus();
        while (doneCycle < 0 && cycleNo < 400) stepCycle();
        if (doneCycle < 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL done_timeout: got no done pulse, required one within 400 cycles (num_words %0d)", v.numWords);
        end else begin
            checkOutput("handshake_count", 64'(hsInXfer), 64'(v.numWords));
            if (v.expDone >= 0) begin
                checkOutput("done_cycle", 64'(doneCycle), 64'(v.expDone));
            end
            if (v.numWords == 0) begin
                checkOutput("zero_len_pops", 64'(popsInCase), 64'(0));
            end
        end
    endtask

    task automatic checkResetValues();
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_done", 64'(done), 64'(0));
        checkOutput("reset_read_req", 64'(bus.fifo_read_req), 64'(0));
        checkOutput("reset_m_valid", 64'(bus.m_valid), 64'(0));
        checkOutput("reset_m_last", 64'(bus.m_last), 64'(0));
        checkOutput("reset_m_data", bus.m_data, 64'(0));
    endtask

    task automatic flushModel();
        fifoQ.delete();
        refQ.delete();
        popsTotal = 0;
        hsTotal   = 0;
        busyExp   = 1'b0;
        doneExp   = 1'b0;
        prevStall = 1'b0;
        bus.fifo_read_ready = 1'b0;
        bus.fifo_read_data  = '0;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{8, 0, 8, 0, 0, -1, 11};
        vecs[1] = '{0, 0, 0, 0, 0, -1, 1};
        vecs[2] = '{1, 0, 1, 0, 0, -1, 4};
        vecs[3] = '{6, 1, 6, 0, 0, -1, -1};
        vecs[4] = '{4, 0, 0, 4, 3, -1, -1};
        vecs[5] = '{8, 0, 8, 0, 0, 4, 11};
        vecs[6] = '{3, 0, 5, 0, 0, -1, 6};
        vecs[7] = '{2, 0, 0, 0, 0, -1, 5};

        reset       = 1'b1;
        start       = 1'b0;
        num_words   = '0;
        bus.m_ready = 1'b0;
        nextWord    = '0;
        randData    = 1'b0;
        hsInXfer    = 0;
        xferLen     = 0;
        cycleNo     = 0;
        prevData    = '0;
        prevLast    = 1'b0;
        flushModel();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkResetValues();

        for (int i = 0; i < 8; i++) begin
            runCase(vecs[i]);
        end

        // Reset after three of ten words have been delivered, then a short fresh transfer.
        readyMode = 0;
        pushLeft  = 0;
        restartAt = -1;
        cycleNo   = 0;
        hsInXfer  = 0;
        repeat (10) pushWord();
        start     = 1'b1;
        num_words = LW'(10);
        applyStimulus();
        while (hsInXfer < 3 && cycleNo < 100) stepCycle();
        checkOutput("pre_reset_handshakes", 64'(hsInXfer), 64'(3));
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        flushModel();
        checkResetValues();
        runCase('{2, 0, 2, 0, 0, -1, 5});

        randData = 1'b1;
        for (int i = 0; i < 20; i++) begin
            int n;
            int p;
            n = int'($urandom_range(1, 20));
            p = int'($urandom_range(0, n));
            runCase('{n, 2, p, n - p, -1, -1, -1});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
